scan_chain_ctrl: RTL
====================

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8: number of scan_dff_mux stages in the controlled chain (stage 0 receives SD, stage CHAIN_LEN-1 drives SO).
REQ-002 SHALL have parameter CNT_W, default $clog2(CHAIN_LEN)+1: width of the internal bit counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port START  input  1  request one shift-in/capture/shift-out test; sampled only in IDLE.
REQ-006 SHALL have port ABORT  input  1  synchronous cancel of a test in progress.
REQ-007 SHALL have port PAT_IN  input  CHAIN_LEN  stimulus pattern; latched on START acceptance.
REQ-008 SHALL have port EXP_IN  input  CHAIN_LEN  expected response; latched on START acceptance.
REQ-009 SHALL have port SO  input  1  scan-out of chain stage CHAIN_LEN-1.
REQ-010 SHALL have port SE  output  1  scan enable to every chain stage.
REQ-011 SHALL have port SD  output  1  scan data into chain stage 0.
REQ-012 SHALL have port BUSY  output  1  high while a test is in progress.
REQ-013 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-014 SHALL have port RESP  output  CHAIN_LEN  captured response; RESP[k] = SO sampled on k-th shift-out cycle.
REQ-015 SHALL have port PASS  output  1  RESP equals latched EXP_IN.

Function
REQ-016 SHALL implement states IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH.
REQ-017 IDLE: START=1 at an edge SHALL latch PAT_IN into a shift register, latch EXP_IN, clear counter, enter SHIFT_IN; START=0 stays IDLE.
REQ-018 SHIFT_IN: SE=1, SD=shift register bit 0; register shifts right (MSB fill 0) and counter increments each edge; after exactly CHAIN_LEN cycles SHALL enter CAPTURE.
REQ-019 CAPTURE: SE=0, SD=0 for exactly 1 cycle (chain loads functional D); then SHIFT_OUT with counter cleared.
REQ-020 SHIFT_OUT: SE=1, SD=0; each edge SHALL write SO into RESP[counter] and increment; after CHAIN_LEN cycles enter FINISH.
REQ-021 FINISH: DONE=1, BUSY=0 for exactly 1 cycle, PASS updated to (RESP==latched EXP), then IDLE.
REQ-022 BUSY SHALL be 1 in SHIFT_IN, CAPTURE, SHIFT_OUT only; START->DONE latency SHALL be 2*CHAIN_LEN+2 cycles.
REQ-023 START while not in IDLE (including FINISH) SHALL be ignored; no queuing.
REQ-024 RESP and PASS SHALL hold their values from FINISH until the next accepted START; on accepted START both SHALL clear to 0.
REQ-025 ABORT in SHIFT_IN, CAPTURE or SHIFT_OUT SHALL return to IDLE at that edge with SE=0, SD=0, no DONE pulse, PASS=0; ABORT in IDLE/FINISH SHALL have no effect.
REQ-026 ABORT and START asserted together in IDLE: START SHALL win.
REQ-027 SE and SD SHALL be registered outputs, glitch-free, changing only on CLK rising edge.

Reset
REQ-028 RST=1 at an edge SHALL force IDLE, SE=0, SD=0, BUSY=0, DONE=0, PASS=0, RESP=0, counter=0, regardless of current state; RST SHALL override START and ABORT.
REQ-029 Reset mid-test SHALL produce no DONE pulse; the first START after RST deasserts SHALL run a full test.

Verification (bench: CHAIN_LEN=4, four scan_dff_mux stages, chain RST tied to controller RST)
REQ-030 Reset: RST high 2 cycles, START=1 -> SE=0, SD=0, BUSY=0, DONE=0, RESP=4'b0000 throughout.
REQ-031 Basic pass: chain D=4'b0011, PAT_IN=4'b1011, EXP_IN=4'b1100, START 1 cycle -> SD sequence 1,1,0,1 with SE=1 for 4 cycles, SE=0 1 cycle, SE=1 4 cycles, DONE at cycle 10, RESP=4'b1100, PASS=1.
REQ-032 Fail: same as REQ-031 with EXP_IN=4'b1101 -> RESP=4'b1100, PASS=0, DONE pulse 1 cycle.
REQ-033 Ignored START: pulse START during SHIFT_OUT and in FINISH -> no restart, single DONE, back to IDLE.
REQ-034 ABORT: assert ABORT on 2nd SHIFT_IN cycle -> IDLE next edge, SE=0, BUSY=0, no DONE, PASS=0.
REQ-035 Reset mid-operation: RST during CAPTURE -> all outputs at reset values next edge; subsequent START completes per REQ-031.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan chain test controller: shift a pattern in, capture one
// functional cycle, shift the response out and compare it.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SD,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 PASS
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    FINISH
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CHAIN_LEN-1:0] sr, sr_n;
  logic [CHAIN_LEN-1:0] expq, exp_n;
  logic [CHAIN_LEN-1:0] resp_n;
  logic                 pass_n;
  logic                 se_n, sd_n;

  // Next state, datapath updates and next values of the registered pins
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    exp_n   = expq;
    resp_n  = RESP;
    pass_n  = PASS;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_n = SHIFT_IN;
          sr_n    = PAT_IN;
          exp_n   = EXP_IN;
          cnt_n   = '0;
          resp_n  = '0;
          pass_n  = 1'b0;
        end
      end
      SHIFT_IN: begin
        if (ABORT) begin
          state_n = IDLE;
          cnt_n   = '0;
          pass_n  = 1'b0;
        end else begin
          sr_n  = sr >> 1;
          cnt_n = cnt + ONE;
          if (cnt == LAST) begin
            state_n = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        state_n = ABORT ? IDLE : SHIFT_OUT;
        cnt_n   = '0;
        if (ABORT) begin
          pass_n = 1'b0;
        end
      end
      SHIFT_OUT: begin
        if (ABORT) begin
          state_n = IDLE;
          cnt_n   = '0;
          pass_n  = 1'b0;
        end else begin
          for (int k = 0; k < CHAIN_LEN; k++) begin
            if (cnt == CNT_W'(k)) begin
              resp_n[k] = SO;
            end
          end
          cnt_n = cnt + ONE;
          if (cnt == LAST) begin
            state_n = FINISH;
            pass_n  = (resp_n == expq);
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    se_n = (state_n == SHIFT_IN) || (state_n == SHIFT_OUT);
    sd_n = (state_n == SHIFT_IN) ? sr_n[0] : 1'b0;
  end

  // State, datapath and glitch-free SE/SD registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      expq  <= '0;
      RESP  <= '0;
      PASS  <= 1'b0;
      SE    <= 1'b0;
      SD    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sr    <= sr_n;
      expq  <= exp_n;
      RESP  <= resp_n;
      PASS  <= pass_n;
      SE    <= se_n;
      SD    <= sd_n;
    end
  end

  assign BUSY = (state == SHIFT_IN) || (state == CAPTURE) ||
                (state == SHIFT_OUT);
  assign DONE = (state == FINISH);

endmodule
